ddr2_i2c_spd_responder: RTL and testbench

I2C target (responder) emulating a 256-byte SPD EEPROM on the DDR2 I2C bus. It is the far end of the software bit-banged SCL/SDA initiator. The block watches SCL/SDA, matches its 7-bit device address, and acknowledges. It services random, current-address and sequential reads and writes against an internal byte memory. A host-side write port preloads SPD contents.

---
 rtl/ddr2_i2c_resp_pkg.sv | 22 ++
 rtl/ddr2_i2c_line_filter.sv | 61 ++++++
 rtl/ddr2_i2c_spd_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_ddr2_i2c_spd_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_i2c_resp_pkg.sv
// Shared types and sizes for the DDR2 SPD I2C responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr2_i2c_resp_pkg;

  localparam int BIT_CNT_W = 3;
  localparam int MEM_DEPTH = 256;
  localparam int PTR_W     = 8;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    DEVACK,
    PTRBYTE,
    PTRACK,
    WRBYTE,
    WRACK,
    RDBYTE,
    RDACK
  } state_e;

endpackage

// File: rtl/ddr2_i2c_line_filter.sv
// Conditions one asynchronous I2C pad: 2-flop synchronizer, stability filter, edge pulses.
// Latency: level/edge pulse appear 2 + FILTER_LEN clk after a clean pin change.
// Backpressure: none; pulses shorter than FILTER_LEN samples are discarded.
module ddr2_i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; accept on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Synchronizer and filter state; idle I2C lines are high, so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ddr2_i2c_spd_responder.sv
// I2C target emulating a 256-byte SPD EEPROM with a host preload port.
// Latency: bus events act 2 + FILTER_LEN clk after the pin; sda_oe moves the clk after a filtered SCL fall.
// Backpressure: none on the host port; host preload wins a same-cycle clash with an I2C write.
module ddr2_i2c_spd_responder
  import ddr2_i2c_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic             wp,
  input  logic             mem_wr_en,
  input  logic [PTR_W-1:0] mem_wr_addr,
  input  logic [7:0]       mem_wr_data,
  output logic             busy,
  output logic             xfer_done
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  ddr2_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk    (clk),
    .rst    (reset),
    .line_in(scl_in),
    .level  (scl_lvl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  ddr2_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk    (clk),
    .rst    (reset),
    .line_in(sda_in),
    .level  (sda_lvl),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 rw_q, rw_d;
  logic                 ack_ok_q, ack_ok_d;   // drive ACK (1) or leave a NACK (0) in the ack slot
  logic                 ack_hi_q, ack_hi_d;   // ninth SCL rise of the ack slot already seen
  logic                 matched_q, matched_d;
  logic                 busy_q, busy_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 xfer_done_q, xfer_done_d;

  logic                 i2c_we;
  logic [7:0]           i2c_wdata;
  logic                 fetch_en;
  logic [PTR_W-1:0]     fetch_addr;
  logic [7:0]           mem_q [MEM_DEPTH];
  logic [7:0]           rd_data_q;

  // Protocol FSM: START/STOP override everything; bits shift on SCL rise, sda_oe moves on SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_ok_d    = ack_ok_q;
    ack_hi_d    = ack_hi_q;
    matched_d   = matched_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    xfer_done_d = 1'b0;
    i2c_we      = 1'b0;
    i2c_wdata   = {shift_q[6:0], sda_lvl};
    fetch_en    = 1'b0;
    fetch_addr  = ptr_q;

    if (stop_det) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      xfer_done_d = matched_q;
      matched_d   = 1'b0;
    end else if (start_det) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      matched_d = 1'b0;
      ack_hi_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end

        DEVADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (&bit_cnt_q) begin
              if (shift_q[6:0] == DEV_ADDR) begin
                state_d   = DEVACK;
                rw_d      = sda_lvl;
                matched_d = 1'b1;
                ack_ok_d  = 1'b1;
                ack_hi_d  = 1'b0;
                fetch_en  = 1'b1;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        DEVACK, PTRACK, WRACK: begin
          if (scl_fall) begin
            if (!ack_hi_q) begin
              sda_oe_d = ack_ok_q;
            end else begin
              ack_hi_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == DEVACK && rw_q) begin
                state_d  = RDBYTE;
                sda_oe_d = ~rd_data_q[7];
                shift_d  = {rd_data_q[6:0], 1'b1};
              end else begin
                sda_oe_d = 1'b0;
                state_d  = (state_q == DEVACK) ? PTRBYTE : WRBYTE;
              end
            end
          end else if (scl_rise) begin
            ack_hi_d = 1'b1;
          end
        end

        PTRBYTE, WRBYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (&bit_cnt_q) begin
              ack_hi_d = 1'b0;
              if (state_q == PTRBYTE) begin
                state_d  = PTRACK;
                ptr_d    = {shift_q[6:0], sda_lvl};
                ack_ok_d = 1'b1;
              end else begin
                state_d  = WRACK;
                ack_ok_d = ~wp;
                if (!wp) begin
                  i2c_we = 1'b1;
                  ptr_d  = ptr_q + 1'b1;
                end
              end
            end
          end
        end

        RDBYTE: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b1};
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (&bit_cnt_q) begin
              // Every byte sent advances the pointer, so a later current-address read
              // resumes after the last byte delivered; prefetch it for a possible ACK.
              state_d    = RDACK;
              ack_hi_d   = 1'b0;
              ptr_d      = ptr_q + 1'b1;
              fetch_en   = 1'b1;
              fetch_addr = ptr_q + 1'b1;
            end
          end
        end

        RDACK: begin
          if (scl_fall) begin
            if (!ack_hi_q) begin
              sda_oe_d = 1'b0;
            end else begin
              state_d   = RDBYTE;
              bit_cnt_d = '0;
              sda_oe_d  = ~rd_data_q[7];
              shift_d   = {rd_data_q[6:0], 1'b1};
              ack_hi_d  = 1'b0;
            end
          end else if (scl_rise) begin
            if (!sda_lvl) begin
              ack_hi_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Control state; reset releases SDA immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_ok_q    <= 1'b0;
      ack_hi_q    <= 1'b0;
      matched_q   <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_ok_q    <= ack_ok_d;
      ack_hi_q    <= ack_hi_d;
      matched_q   <= matched_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  // Byte store: one write port (host preload has priority) and a registered read port.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[mem_wr_addr] <= mem_wr_data;
    end else if (i2c_we) begin
      mem_q[ptr_q] <= i2c_wdata;
    end
    if (fetch_en) begin
      rd_data_q <= mem_q[fetch_addr];
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign xfer_done = xfer_done_q;

endmodule

// File: tb/tb_ddr2_i2c_spd_responder.sv
// Bench for the SPD responder: bit-banged I2C initiator plus a transaction-level EEPROM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr2_i2c_spd_responder;

  localparam logic [6:0] DEV = 7'h50;
  localparam int H = 12;  // SCL half period in clk cycles
  localparam int Q = 6;   // data setup point inside the low phase

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       wp = 1'b0;
  logic       mem_wr_en = 1'b0;
  logic [7:0] mem_wr_addr = 8'h00;
  logic [7:0] mem_wr_data = 8'h00;
  logic       sda_oe, busy, xfer_done;
  logic       sda_bus;

  // Open-drain bus: low if either side pulls it low.
  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  ddr2_i2c_spd_responder #(.DEV_ADDR(DEV), .FILTER_LEN(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (m_scl),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .wp         (wp),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy       (busy),
    .xfer_done  (xfer_done)
  );

  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int done_cnt = 0;

  logic [7:0] mem_m [256];
  logic [7:0] ptr_m = 8'h00;
  logic [7:0] wbuf [8];
  logic [7:0] coll_addr = 8'h00;
  logic [7:0] coll_data = 8'h00;

  // Cycle counters of sda_oe assertion and xfer_done pulses.
  always @(posedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (xfer_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    mem_wr_en = 1'b1; mem_wr_addr = a; mem_wr_data = d;
    tick(1);
    mem_wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  // One SCL clock; SCL is low on entry and exit. r is the bus level sampled mid-high.
  task automatic bit_xfer(input logic b, input bit glitch, input bit coll, output logic r);
    m_sda = b;
    if (glitch) begin
      tick(2); m_scl = 1'b1; tick(1); m_scl = 1'b0; tick(Q - 3);
    end else begin
      tick(Q);
    end
    m_scl = 1'b1;
    if (coll) begin
      mem_wr_en = 1'b1; mem_wr_addr = coll_addr; mem_wr_data = coll_data;
    end
    if (glitch) begin
      tick(2); m_sda = ~b; tick(1); m_sda = b; tick(H/2 - 3);
    end else begin
      tick(H/2);
    end
    r = sda_bus;
    tick(H/2 - 1);
    mem_wr_en = 1'b0;
    tick(1);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic start_c();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b0; tick(H);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b1; tick(H);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit glitch, input bit coll, output bit acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], glitch, coll && (i == 0), r);
    bit_xfer(1'b1, 1'b0, 1'b0, r);
    acked = (r == 1'b0);
  endtask

  task automatic recv_byte(input bit ack_it, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, 1'b0, r);
      d[i] = r;
    end
    bit_xfer(~ack_it, 1'b0, 1'b0, r);
  endtask

  // Write transaction: device byte, pointer, n data bytes from wbuf, STOP.
  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] p, input int n,
                        input bit glitch, input bit coll, input logic [7:0] cdat);
    bit a;
    int d0, o0;
    d0 = done_cnt;
    start_c();
    o0 = oe_cnt;
    send_byte({dev, 1'b0}, 1'b0, 1'b0, a);
    chk("wr_dev_ack", a, dev == DEV);
    if (dev != DEV) begin
      chk("nomatch_oe", oe_cnt - o0, 0);
      chk("nomatch_busy", busy, 0);
    end else begin
      send_byte(p, 1'b0, 1'b0, a);
      chk("wr_ptr_ack", a, 1);
      ptr_m = p;
      for (int k = 0; k < n; k++) begin
        coll_addr = ptr_m;
        coll_data = cdat;
        send_byte(wbuf[k], glitch, coll && (k == 0), a);
        chk("wr_dat_ack", a, !wp);
        if (coll && k == 0) mem_m[coll_addr] = cdat;
        else if (!wp) mem_m[ptr_m] = wbuf[k];
        if (!wp) ptr_m++;
      end
      chk("wr_busy", busy, 1);
    end
    stop_c();
    chk("wr_done", done_cnt - d0, dev == DEV);
  endtask

  // Read transaction: optional pointer set + repeated START, then n bytes, NACK on the last.
  task automatic rd_txn(input bit set_ptr, input logic [7:0] p, input int n);
    bit a;
    logic [7:0] d;
    int d0;
    d0 = done_cnt;
    if (set_ptr) begin
      start_c();
      send_byte({DEV, 1'b0}, 1'b0, 1'b0, a);
      chk("rd_wdev_ack", a, 1);
      send_byte(p, 1'b0, 1'b0, a);
      chk("rd_ptr_ack", a, 1);
      ptr_m = p;
    end
    start_c();
    send_byte({DEV, 1'b1}, 1'b0, 1'b0, a);
    chk("rd_dev_ack", a, 1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k != n - 1, d);
      chk("rd_data", d, mem_m[ptr_m]);
      ptr_m++;
    end
    chk("rd_busy", busy, 1);
    stop_c();
    chk("rd_done", done_cnt - d0, 1);
    chk("rd_idle_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic r;
    bit   a;
    int   sel, n;
    logic [7:0] p;

    tick(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xfer_done", xfer_done, 0);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 256; i++) host_wr(8'(i), 8'($urandom));

    // Random read of a preloaded byte after a pointer write and repeated START.
    host_wr(8'h00, 8'hA5);
    rd_txn(1'b1, 8'h00, 1);

    // Wrong device address (0xA2 on the wire).
    wr_txn(7'h51, 8'h00, 0, 1'b0, 1'b0, 8'h00);

    // Sequential read across the 0xFF -> 0x00 wrap, then a current-address read at 0x01.
    host_wr(8'hFE, 8'h11);
    host_wr(8'hFF, 8'h22);
    host_wr(8'h00, 8'h33);
    host_wr(8'h01, 8'h5C);
    rd_txn(1'b1, 8'hFE, 3);
    rd_txn(1'b0, 8'h00, 1);

    // Write protect.
    host_wr(8'h10, 8'hC3);
    wp = 1'b1;
    wbuf[0] = 8'h5A;
    wr_txn(DEV, 8'h10, 1, 1'b0, 1'b0, 8'h00);
    wp = 1'b0;
    rd_txn(1'b1, 8'h10, 1);

    // Host preload collides with the first I2C data byte.
    wbuf[0] = 8'h99;
    wbuf[1] = 8'h44;
    wr_txn(DEV, 8'h20, 2, 1'b0, 1'b1, 8'h77);
    rd_txn(1'b1, 8'h20, 2);

    // One-clk SCL glitches in the low phase and SDA glitches in the high phase.
    wbuf[0] = 8'h3C;
    wbuf[1] = 8'hC9;
    wr_txn(DEV, 8'h30, 2, 1'b1, 1'b0, 8'h00);
    rd_txn(1'b1, 8'h30, 2);

    // Reset while the device drives the address ACK.
    start_c();
    for (int i = 7; i >= 0; i--) bit_xfer(DEV_BYTE(i), 1'b0, 1'b0, r);
    m_sda = 1'b1;
    for (int t = 0; t < 40 && !sda_oe; t++) tick(1);
    chk("ack_before_reset", sda_oe, 1);
    #2 reset = 1'b1;
    #1 chk("rst_async_oe", sda_oe, 0);
    chk("rst_async_busy", busy, 0);
    tick(2);
    m_sda = 1'b1;
    m_scl = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(H);
    ptr_m = 8'h00;
    rd_txn(1'b0, 8'h00, 1);

    // Randomized transactions against the model.
    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 9);
      n   = $urandom_range(1, 4);
      p   = 8'($urandom);
      if (sel == 0) begin
        wr_txn(DEV ^ 7'($urandom_range(1, 127)), p, 0, 1'b0, 1'b0, 8'h00);
      end else if (sel <= 2) begin
        host_wr(p, 8'($urandom));
      end else if (sel <= 5) begin
        for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
        wp = ($urandom_range(0, 3) == 0);
        wr_txn(DEV, p, n, 1'b0, 1'b0, 8'h00);
        wp = 1'b0;
      end else if (sel <= 7) begin
        rd_txn(1'b1, p, n);
      end else begin
        rd_txn(1'b0, 8'h00, n);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic DEV_BYTE(input int i);
    logic [7:0] v;
    v = {DEV, 1'b0};
    return v[i];
  endfunction

endmodule
